// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg
//   Shared definitions for the PWM capture block: the measurement FSM state
//   encoding used by pwm_capture.
//   Optional feature macro (consumed by pwm_edge_sync): PWM_CAPTURE_FILTER_EN.
package pwm_capture_pkg;

    // Measurement FSM states; encodings are fixed so they read the same in
    // waveforms and in any external debug tooling.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } cap_state_e;

    // Smallest synchroniser depth that is still metastability-safe.
    localparam int MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/pwm_edge_sync.sv
// pwm_edge_sync
//   Brings the asynchronous PWM waveform into the clk domain and turns the
//   resulting level into single-cycle rise/fall strobes.
//   pwm_in -> SYNC_STAGES flops -> (optional glitch filter) -> level,
//   level delayed one cycle -> level_d, rise = level & ~level_d,
//   fall = ~level & level_d.
//   Macro PWM_CAPTURE_FILTER_EN: when defined, the level only changes after
//   FILT_LEN consecutive equal samples, so pulses shorter than FILT_LEN are
//   dropped and both edges are delayed by FILT_LEN cycles. When undefined,
//   every sampled level change is an edge and FILT_LEN has no effect.
// Ports
//   clk     in   1   clock, all state on posedge
//   rst     in   1   synchronous, active-high reset
//   pwm_in  in   1   asynchronous PWM input
//   rise    out  1   level went 0 -> 1 this cycle
//   fall    out  1   level went 1 -> 0 this cycle
module pwm_edge_sync
    import pwm_capture_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic rise,
    output logic fall
);

    localparam int STAGES = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int FILT_USE = FILT_LEN;
`else
    // Filter length collapses to zero: the level is taken straight from the
    // synchroniser.
    localparam int FILT_USE = 0 * FILT_LEN;
`endif

    logic [STAGES-1:0] sync_r;
    logic              sync_s;
    logic              level_s;
    logic              level_d_r;

    // Synchroniser chain on the asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], pwm_in};
        end
    end

    assign sync_s = sync_r[STAGES-1];

    generate
        if (FILT_USE > 0) begin : g_filt
            localparam int             FCW      = (FILT_USE > 1) ? $clog2(FILT_USE) : 1;
            localparam logic [FCW-1:0] CNT_LAST = FCW'(FILT_USE - 1);

            logic [FCW-1:0] cnt_r;
            logic           filt_r;

            // Counts consecutive samples that disagree with the filtered level;
            // the level follows only once FILT_LEN of them have been seen.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_r  <= {FCW{1'b0}};
                    filt_r <= 1'b0;
                end else if (sync_s == filt_r) begin
                    cnt_r  <= {FCW{1'b0}};
                end else if (cnt_r == CNT_LAST) begin
                    cnt_r  <= {FCW{1'b0}};
                    filt_r <= sync_s;
                end else begin
                    cnt_r  <= cnt_r + FCW'(1'b1);
                end
            end

            assign level_s = filt_r;
        end else begin : g_nofilt
            assign level_s = sync_s;
        end
    endgenerate

    // Previous-cycle level for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_d_r <= 1'b0;
        end else begin
            level_d_r <= level_s;
        end
    end

    assign rise = level_s & ~level_d_r;
    assign fall = ~level_s & level_d_r;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture
//   Measures a PWM waveform: for each rising-edge-to-rising-edge period it
//   reports the number of clk cycles the input was high and the period
//   length, over a valid/ready result channel. A period that never closes
//   (0% / 100% duty or a too-long period) is reported with period = all-ones
//   and overflow = 1, after which the block re-arms.
//   Macro PWM_CAPTURE_FILTER_EN enables the glitch filter in pwm_edge_sync.
// Parameters
//   CNT_WIDTH    counter and result field width
//   SYNC_STAGES  synchroniser depth on pwm_in (>= 2)
//   FILT_LEN     glitch filter length (only with PWM_CAPTURE_FILTER_EN)
// Ports
//   clk        in   1          clock
//   rst        in   1          synchronous, active-high reset
//   enable     in   1          capture enable; low returns FSM to IDLE
//   pwm_in     in   1          asynchronous PWM waveform
//   m_valid    out  1          result available
//   m_ready    in   1          consumer accepts result
//   high_time  out  CNT_WIDTH  high cycles in the measured period
//   period     out  CNT_WIDTH  rising edge to next rising edge, in cycles
//   overflow   out  1          period counter saturated without closing edge
//   overrun    out  1          an unconsumed result was overwritten
//   busy       out  1          FSM not in IDLE
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_WIDTH   = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 pwm_in,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [CNT_WIDTH-1:0] high_time,
    output logic [CNT_WIDTH-1:0] period,
    output logic                 overflow,
    output logic                 overrun,
    output logic                 busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    // Saturating increment: counters stick at all-ones.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        logic [CNT_WIDTH-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    cap_state_e           state_r;
    cap_state_e           state_nxt_s;
    logic [CNT_WIDTH-1:0] hi_cnt_r;
    logic [CNT_WIDTH-1:0] per_cnt_r;
    logic [CNT_WIDTH-1:0] hi_nxt_s;
    logic [CNT_WIDTH-1:0] per_nxt_s;
    logic                 load_s;
    logic                 load_ovf_s;
    logic [CNT_WIDTH-1:0] load_hi_s;
    logic [CNT_WIDTH-1:0] load_per_s;
    logic                 rise_s;
    logic                 fall_s;

    pwm_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
    ) u_edge_sync (
        .clk   (clk),
        .rst   (rst),
        .pwm_in(pwm_in),
        .rise  (rise_s),
        .fall  (fall_s)
    );

    // Next-state, counter update and result-load decisions.
    always_comb begin
        state_nxt_s = state_r;
        hi_nxt_s    = hi_cnt_r;
        per_nxt_s   = per_cnt_r;
        load_s      = 1'b0;
        load_ovf_s  = 1'b0;
        load_hi_s   = hi_cnt_r;
        load_per_s  = per_cnt_r;

        if (!enable) begin
            // Abandon any partial period; the pending result is untouched.
            state_nxt_s = ST_IDLE;
            hi_nxt_s    = CNT_ZERO;
            per_nxt_s   = CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_ARM;
                    hi_nxt_s    = CNT_ZERO;
                    per_nxt_s   = CNT_ZERO;
                end
                ST_ARM: begin
                    // First rise only opens a period; nothing is reported.
                    if (rise_s) begin
                        state_nxt_s = ST_HIGH;
                        hi_nxt_s    = CNT_ONE;
                        per_nxt_s   = CNT_ONE;
                    end else begin
                        hi_nxt_s    = CNT_ZERO;
                        per_nxt_s   = CNT_ZERO;
                    end
                end
                ST_HIGH: begin
                    if (per_cnt_r == CNT_MAX) begin
                        load_s      = 1'b1;
                        load_ovf_s  = 1'b1;
                        load_per_s  = CNT_MAX;
                        state_nxt_s = ST_ARM;
                        hi_nxt_s    = CNT_ZERO;
                        per_nxt_s   = CNT_ZERO;
                    end else if (fall_s) begin
                        // The fall cycle is already low: period only.
                        state_nxt_s = ST_LOW;
                        per_nxt_s   = sat_inc(per_cnt_r);
                    end else begin
                        hi_nxt_s    = sat_inc(hi_cnt_r);
                        per_nxt_s   = sat_inc(per_cnt_r);
                    end
                end
                ST_LOW: begin
                    if (rise_s) begin
                        // Closing rise also opens the next period.
                        load_s      = 1'b1;
                        state_nxt_s = ST_HIGH;
                        hi_nxt_s    = CNT_ONE;
                        per_nxt_s   = CNT_ONE;
                    end else if (per_cnt_r == CNT_MAX) begin
                        load_s      = 1'b1;
                        load_ovf_s  = 1'b1;
                        load_per_s  = CNT_MAX;
                        state_nxt_s = ST_ARM;
                        hi_nxt_s    = CNT_ZERO;
                        per_nxt_s   = CNT_ZERO;
                    end else begin
                        per_nxt_s   = sat_inc(per_cnt_r);
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    hi_nxt_s    = CNT_ZERO;
                    per_nxt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // FSM state, counters and registered busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            hi_cnt_r  <= CNT_ZERO;
            per_cnt_r <= CNT_ZERO;
            busy      <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            hi_cnt_r  <= hi_nxt_s;
            per_cnt_r <= per_nxt_s;
            busy      <= (state_nxt_s != ST_IDLE);
        end
    end

    // Result register and valid/ready handshake; a load wins over an accept
    // so a result arriving with an accept is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid   <= 1'b0;
            high_time <= CNT_ZERO;
            period    <= CNT_ZERO;
            overflow  <= 1'b0;
            overrun   <= 1'b0;
        end else if (load_s) begin
            m_valid   <= 1'b1;
            high_time <= load_hi_s;
            period    <= load_per_s;
            overflow  <= load_ovf_s;
            overrun   <= m_valid & ~m_ready;
        end else if (m_valid && m_ready) begin
            m_valid   <= 1'b0;
        end else begin
            m_valid   <= m_valid;
        end
    end

endmodule
